// File: rtl/crc_code_encoder.sv
// Serial CRC-4 encoder (x^4 + x + 1): shifts an 8-bit word MSB first through an
// LFSR and emits the 12-bit codeword {data, crc} with a one-cycle done pulse.
module crc_code_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_in,
  input  logic        start,
  output logic [11:0] encoded_data,
  output logic        busy,
  output logic        done
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  hold_q, hold_d;
  logic [3:0]  lfsr_q, lfsr_d;
  logic [2:0]  count_q, count_d;
  logic [11:0] code_q, code_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        feedback;
  logic [3:0]  lfsr_step;

  // One division step: the bit leaving lfsr[3] combined with the incoming data bit
  // decides whether the low polynomial terms (x + 1) are folded back in.
  always_comb begin
    feedback  = lfsr_q[3] ^ shift_q[7];
    lfsr_step = {lfsr_q[2:0], 1'b0} ^ (feedback ? 4'b0011 : 4'b0000);
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    hold_d  = hold_q;
    lfsr_d  = lfsr_q;
    count_d = count_q;
    code_d  = code_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          shift_d = data_in;
          hold_d  = data_in;
          lfsr_d  = 4'h0;
          count_d = 3'd0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift_d = {shift_q[6:0], 1'b0};
        lfsr_d  = lfsr_step;
        count_d = count_q + 3'd1;
        // The eighth shift publishes the codeword and frees the encoder in the same edge.
        if (count_q == 3'd7) begin
          count_d = 3'd0;
          code_d  = {hold_q, lfsr_step};
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= 8'h00;
      hold_q  <= 8'h00;
      lfsr_q  <= 4'h0;
      count_q <= 3'd0;
      code_q  <= 12'h000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      lfsr_q  <= lfsr_d;
      count_q <= count_d;
      code_q  <= code_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign encoded_data = code_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_crc_code_encoder.sv
// Self-checking bench for crc_code_encoder: directed vectors, back-to-back, ignored
// start, mid-shift reset and an all-values round trip against a long-division model.
module tb_crc_code_encoder;

  logic        clk;
  logic        rst;
  logic [7:0]  data_in;
  logic        start;
  logic [11:0] encoded_data;
  logic        busy;
  logic        done;

  int tests;
  int fails;

  crc_code_encoder dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .start        (start),
    .encoded_data (encoded_data),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Polynomial long division of a value by x^4 + x + 1 (0x13), returning the remainder.
  function automatic logic [3:0] poly_mod(input int value, input int top_bit);
    int r;
    r = value;
    for (int i = top_bit; i >= 4; i--) begin
      if (((r >> i) & 1) != 0) r = r ^ (32'h13 << (i - 4));
    end
    return r[3:0];
  endfunction

  function automatic logic [11:0] model_code(input logic [7:0] d);
    logic [3:0] crc;
    crc = poly_mod(int'(d) << 4, 11);
    return {d, crc};
  endfunction

  // Called at a falling edge; returns at the falling edge after the completion edge.
  task automatic run_word(input logic [7:0] d, input logic [11:0] expected, input string name);
    data_in = d;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tests++;
      if ({busy, done} !== 2'b10) begin
        fails++;
        $display("[TB] FAIL %s shift cycle %0d: busy,done=%b expected 10", name, k, {busy, done});
      end
      @(negedge clk);
    end
    tests++;
    if ({busy, done} !== 2'b01) begin
      fails++;
      $display("[TB] FAIL %s done cycle: busy,done=%b expected 01", name, {busy, done});
    end
    tests++;
    if (encoded_data !== expected) begin
      fails++;
      $display("[TB] FAIL %s codeword: got %h expected %h", name, encoded_data, expected);
    end
  endtask

  task automatic idle_check(input logic [11:0] expected, input string name);
    @(negedge clk);
    tests++;
    if ({busy, done} !== 2'b00 || encoded_data !== expected) begin
      fails++;
      $display("[TB] FAIL %s idle: busy,done=%b code=%h expected 00 code=%h",
               name, {busy, done}, encoded_data, expected);
    end
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    start   = 1'b0;
    data_in = 8'h00;
    repeat (2) @(negedge clk);
    tests++;
    if (encoded_data !== 12'h000 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset state: code=%h busy=%b done=%b expected 000 0 0",
               encoded_data, busy, done);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [7:0]  vec_d [5] = '{8'h00, 8'h01, 8'h80, 8'hFF, 8'hA5};
    logic [11:0] vec_c [5] = '{12'h000, 12'h013, 12'h80E, 12'hFF4, 12'hA5B};
    for (int i = 0; i < 5; i++) begin
      run_word(vec_d[i], vec_c[i], "directed");
      tests++;
      if (model_code(vec_d[i]) !== vec_c[i]) begin
        fails++;
        $display("[TB] FAIL model vector %h: got %h expected %h", vec_d[i], model_code(vec_d[i]), vec_c[i]);
      end
      idle_check(vec_c[i], "directed");
    end
  endtask

  task automatic test_back_to_back();
    run_word(8'hA5, 12'hA5B, "b2b_first");
    run_word(8'hFF, 12'hFF4, "b2b_second");
    idle_check(12'hFF4, "b2b");
  endtask

  task automatic test_ignored_start();
    data_in = 8'h01;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k == 2) begin start = 1'b1; data_in = 8'hFF; end
      if (k == 3) begin start = 1'b0; data_in = 8'h3C; end
      if (k == 5) begin start = 1'b1; data_in = 8'h00; end
      if (k == 6) begin start = 1'b0; data_in = 8'hC3; end
      tests++;
      if ({busy, done} !== 2'b10) begin
        fails++;
        $display("[TB] FAIL ignored_start cycle %0d: busy,done=%b expected 10", k, {busy, done});
      end
      @(negedge clk);
    end
    tests++;
    if (done !== 1'b1 || encoded_data !== 12'h013) begin
      fails++;
      $display("[TB] FAIL ignored_start result: done=%b code=%h expected 1 013", done, encoded_data);
    end
    for (int k = 0; k < 10; k++) idle_check(12'h013, "ignored_start_hold");
  endtask

  task automatic test_reset_mid_shift();
    data_in = 8'h80;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reset_mid busy before reset: got %b expected 1", busy);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (encoded_data !== 12'h000 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_mid async clear: code=%h busy=%b done=%b expected 000 0 0",
               encoded_data, busy, done);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("[TB] FAIL reset_mid held: busy=%b done=%b expected 0 0", busy, done);
      end
    end
    rst = 1'b0;
    for (int k = 0; k < 6; k++) idle_check(12'h000, "reset_mid_no_done");
    run_word(8'h80, 12'h80E, "reset_mid_restart");
    idle_check(12'h80E, "reset_mid_restart");
  endtask

  task automatic test_random();
    logic [7:0] d;
    for (int i = 0; i < 24; i++) begin
      d = 8'($urandom_range(0, 255));
      run_word(d, model_code(d), "random");
      if ($urandom_range(0, 1) == 1) idle_check(model_code(d), "random");
    end
    @(negedge clk);
  endtask

  task automatic test_round_trip();
    for (int v = 0; v < 256; v++) begin
      run_word(8'(v), model_code(8'(v)), "round_trip");
      tests++;
      if (poly_mod(int'(encoded_data), 11) !== 4'h0 || encoded_data[11:4] !== 8'(v)) begin
        fails++;
        $display("[TB] FAIL round_trip %h: code=%h remainder=%h expected remainder 0 data %h",
                 v[7:0], encoded_data, poly_mod(int'(encoded_data), 11), v[7:0]);
      end
    end
    idle_check(model_code(8'hFF), "round_trip_end");
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    rst     = 1'b1;
    start   = 1'b0;
    data_in = 8'h00;
    test_reset();
    test_directed();
    test_back_to_back();
    test_ignored_start();
    test_reset_mid_shift();
    test_random();
    test_round_trip();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
